// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings and constants for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic {
        RUN,
        STALL
    } stall_state_e;

    typedef enum logic [1:0] {
        RUN_H,
        DRAIN,
        HALTED
    } halt_state_e;

    localparam logic [15:0] NOP_INST = 16'h1000;

    function automatic bit load_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand forwarding priority select (MEM, then WB, then register file)
module fwd_mux #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic              mem_memread,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wen,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data
);

    always_comb begin
        fwd_data = rf_data;
        if ((ZERO_REG != 0) && (src == '0)) begin
            fwd_data = '0;
        end else if (mem_wen && (mem_rd == src) && (!mem_memread || (LOAD_LAT == 1))) begin
            // with a two-cycle load the MEM-stage value is still an address, not load data
            fwd_data = mem_data;
        end else if (wb_wen && (wb_rd == src)) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use stall, redirect flush, halt drain and perf counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [DATA_W-1:0] ex_rs1_data,
    input  logic [DATA_W-1:0] ex_rs2_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic              ex_memread,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic              mem_memread,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wen,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_halt,
    output logic [DATA_W-1:0] fwd_rs1,
    output logic [DATA_W-1:0] fwd_rs2,
    output logic              hold_pc,
    output logic              hold_d,
    output logic              kill_d,
    output logic              kill_ex,
    output logic              fetch_en,
    output logic              halted,
    output logic [CNT_W-1:0]  cnt_cycles,
    output logic [CNT_W-1:0]  cnt_stalls,
    output logic [CNT_W-1:0]  cnt_flushes
);

    if (!load_lat_ok(LOAD_LAT)) begin : g_bad_load_lat
        $error("pipe_hazard_ctrl: LOAD_LAT must be 1 or 2");
    end

    localparam logic STALL_LAST = 1'b0;

    stall_state_e stall_q, stall_d;
    halt_state_e  halt_q, halt_d;
    logic         scnt_q, scnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, stl_q, stl_d, flu_q, flu_d;

    logic ex_load_hit, mem_load_hit, detect, stalling;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG)) u_fwd_rs1 (
        .src(ex_rs1), .rf_data(ex_rs1_data),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_memread(mem_memread), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data), .fwd_data(fwd_rs1)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG)) u_fwd_rs2 (
        .src(ex_rs2), .rf_data(ex_rs2_data),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_memread(mem_memread), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data), .fwd_data(fwd_rs2)
    );

    always_comb begin
        ex_load_hit  = ex_memread && ex_wen &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd))) &&
                       !((ZERO_REG != 0) && (ex_rd == '0));
        mem_load_hit = (LOAD_LAT == 2) && mem_memread && mem_wen &&
                       ((id_rs1_used && (id_rs1 == mem_rd)) || (id_rs2_used && (id_rs2 == mem_rd))) &&
                       !((ZERO_REG != 0) && (mem_rd == '0));
        detect       = ex_load_hit || mem_load_hit;
        stalling     = (stall_q == STALL) || detect;
    end

    // stall sequencer; a redirect squashes the dependent instruction so any pending stall is moot
    always_comb begin
        stall_d = stall_q;
        scnt_d  = scnt_q;
        if (ex_redirect) begin
            stall_d = RUN;
            scnt_d  = 1'b0;
        end else if (stall_q == RUN) begin
            if ((LOAD_LAT == 2) && ex_load_hit) begin
                stall_d = STALL;
                scnt_d  = 1'b0;
            end
        end else if (scnt_q == STALL_LAST) begin
            stall_d = RUN;
            scnt_d  = 1'b0;
        end else begin
            scnt_d = scnt_q + 1'b1;
        end
    end

    always_comb begin
        halt_d = halt_q;
        case (halt_q)
            RUN_H:   if (id_halt && !ex_redirect && !stalling) halt_d = DRAIN;
            DRAIN:   if (wb_halt) halt_d = HALTED;
            HALTED:  halt_d = HALTED;
            default: halt_d = RUN_H;
        endcase
    end

    always_comb begin
        hold_pc  = stalling && !ex_redirect && !rst;
        hold_d   = hold_pc;
        kill_ex  = rst || ex_redirect || stalling || (halt_q == HALTED);
        kill_d   = rst || ex_redirect || (halt_q == DRAIN) || (halt_q == HALTED);
        fetch_en = rst || (halt_q == RUN_H);
        halted   = !rst && (halt_q == HALTED);
    end

    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        flu_d = flu_q;
        if ((halt_q != HALTED) && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
        if (hold_pc && (stl_q != '1))            stl_d = stl_q + 1'b1;
        if (ex_redirect && (flu_q != '1))        flu_d = flu_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= RUN;
            scnt_q  <= 1'b0;
            halt_q  <= RUN_H;
            cyc_q   <= '0;
            stl_q   <= '0;
            flu_q   <= '0;
        end else begin
            stall_q <= stall_d;
            scnt_q  <= scnt_d;
            halt_q  <= halt_d;
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
            flu_q   <= flu_d;
        end
    end

    assign cnt_cycles  = cyc_q;
    assign cnt_stalls  = stl_q;
    assign cnt_flushes = flu_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl across three parameter sets
module tb_pipe_hazard_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_rs1_used, id_rs2_used, id_halt;
    logic [DW-1:0] ex_rs1_data, ex_rs2_data, mem_data, wb_data;
    logic          ex_wen, ex_memread, ex_redirect, mem_wen, mem_memread, wb_wen, wb_halt;

    logic [DW-1:0] a_fwd1, a_fwd2, b_fwd1, b_fwd2, c_fwd1, c_fwd2;
    logic          a_hold_pc, a_hold_d, a_kill_d, a_kill_ex, a_fetch, a_halted;
    logic          b_hold_pc, b_hold_d, b_kill_d, b_kill_ex, b_fetch, b_halted;
    logic          c_hold_pc, c_hold_d, c_kill_d, c_kill_ex, c_fetch, c_halted;
    logic [31:0]   a_cyc, a_stl, a_flu, b_cyc, b_stl, b_flu;
    logic [3:0]    c_cyc, c_stl, c_flu;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] e;

    // a: LOAD_LAT=1, ZERO_REG=0   b: LOAD_LAT=2, ZERO_REG=1   c: CNT_W=4
    pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .LOAD_LAT(1), .ZERO_REG(0), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_halt(id_halt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_wen(mem_wen),
        .mem_memread(mem_memread), .mem_data(mem_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .wb_data(wb_data), .wb_halt(wb_halt), .fwd_rs1(a_fwd1), .fwd_rs2(a_fwd2),
        .hold_pc(a_hold_pc), .hold_d(a_hold_d), .kill_d(a_kill_d), .kill_ex(a_kill_ex),
        .fetch_en(a_fetch), .halted(a_halted), .cnt_cycles(a_cyc), .cnt_stalls(a_stl),
        .cnt_flushes(a_flu)
    );

    pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_halt(id_halt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_wen(mem_wen),
        .mem_memread(mem_memread), .mem_data(mem_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .wb_data(wb_data), .wb_halt(wb_halt), .fwd_rs1(b_fwd1), .fwd_rs2(b_fwd2),
        .hold_pc(b_hold_pc), .hold_d(b_hold_d), .kill_d(b_kill_d), .kill_ex(b_kill_ex),
        .fetch_en(b_fetch), .halted(b_halted), .cnt_cycles(b_cyc), .cnt_stalls(b_stl),
        .cnt_flushes(b_flu)
    );

    pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .LOAD_LAT(1), .ZERO_REG(0), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_halt(id_halt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_wen(mem_wen),
        .mem_memread(mem_memread), .mem_data(mem_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .wb_data(wb_data), .wb_halt(wb_halt), .fwd_rs1(c_fwd1), .fwd_rs2(c_fwd2),
        .hold_pc(c_hold_pc), .hold_d(c_hold_d), .kill_d(c_kill_d), .kill_ex(c_kill_ex),
        .fetch_en(c_fetch), .halted(c_halted), .cnt_cycles(c_cyc), .cnt_stalls(c_stl),
        .cnt_flushes(c_flu)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_halt = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rs1_data = '0; ex_rs2_data = '0; ex_rd = '0;
        ex_wen = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
        mem_rd = '0; mem_wen = 1'b0; mem_memread = 1'b0; mem_data = '0;
        wb_rd = '0; wb_wen = 1'b0; wb_data = '0; wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_use_stim();
        ex_memread = 1'b1; ex_wen = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2; id_rs1_used = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        sb.push_back(1); sb.push_back(1); sb.push_back(1); sb.push_back(0); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (a_kill_d !== e) begin n_fail++; $display("FAIL rst_kill_d got=%0h exp=%0h", a_kill_d, e); end
        n_run++; e = sb.pop_front(); if (a_kill_ex !== e) begin n_fail++; $display("FAIL rst_kill_ex got=%0h exp=%0h", a_kill_ex, e); end
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL rst_fetch_en got=%0h exp=%0h", a_fetch, e); end
        n_run++; e = sb.pop_front(); if (a_halted !== e) begin n_fail++; $display("FAIL rst_halted got=%0h exp=%0h", a_halted, e); end
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL rst_hold_pc got=%0h exp=%0h", a_hold_pc, e); end
        tick();
        rst = 1'b0;
        sb.push_back(0); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (a_cyc !== e) begin n_fail++; $display("FAIL rst_cnt_cycles got=%0h exp=%0h", a_cyc, e); end
        n_run++; e = sb.pop_front(); if (b_stl !== e) begin n_fail++; $display("FAIL rst_cnt_stalls got=%0h exp=%0h", b_stl, e); end
    endtask

    task automatic test_forward();
        do_reset();
        mem_wen = 1'b1; mem_rd = 3'd3; mem_data = 32'hAAAA;
        wb_wen = 1'b1; wb_rd = 3'd3; wb_data = 32'h5555;
        ex_rs1 = 3'd3; ex_rs1_data = 32'h1111; ex_rs2 = 3'd4; ex_rs2_data = 32'h2222;
        sb.push_back(32'hAAAA); sb.push_back(32'h2222);
        #1;
        n_run++; e = sb.pop_front(); if (a_fwd1 !== e) begin n_fail++; $display("FAIL fwd_mem got=%0h exp=%0h", a_fwd1, e); end
        n_run++; e = sb.pop_front(); if (a_fwd2 !== e) begin n_fail++; $display("FAIL fwd_rf got=%0h exp=%0h", a_fwd2, e); end
        mem_memread = 1'b1;
        sb.push_back(32'hAAAA); sb.push_back(32'h5555);
        #1;
        n_run++; e = sb.pop_front(); if (a_fwd1 !== e) begin n_fail++; $display("FAIL fwd_memload_lat1 got=%0h exp=%0h", a_fwd1, e); end
        n_run++; e = sb.pop_front(); if (b_fwd1 !== e) begin n_fail++; $display("FAIL fwd_memload_lat2 got=%0h exp=%0h", b_fwd1, e); end
        mem_memread = 1'b0; mem_wen = 1'b0;
        sb.push_back(32'h5555);
        #1;
        n_run++; e = sb.pop_front(); if (a_fwd1 !== e) begin n_fail++; $display("FAIL fwd_wb got=%0h exp=%0h", a_fwd1, e); end
        mem_wen = 1'b1; mem_rd = 3'd0; wb_rd = 3'd0; ex_rs1 = 3'd0;
        sb.push_back(32'h0); sb.push_back(32'hAAAA);
        #1;
        n_run++; e = sb.pop_front(); if (b_fwd1 !== e) begin n_fail++; $display("FAIL fwd_zero_reg got=%0h exp=%0h", b_fwd1, e); end
        n_run++; e = sb.pop_front(); if (a_fwd1 !== e) begin n_fail++; $display("FAIL fwd_r0_forwarded got=%0h exp=%0h", a_fwd1, e); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        load_use_stim();
        sb.push_back(1); sb.push_back(1); sb.push_back(1); sb.push_back(0); sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL lu_hold_pc got=%0h exp=%0h", a_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (a_hold_d !== e) begin n_fail++; $display("FAIL lu_hold_d got=%0h exp=%0h", a_hold_d, e); end
        n_run++; e = sb.pop_front(); if (a_kill_ex !== e) begin n_fail++; $display("FAIL lu_kill_ex got=%0h exp=%0h", a_kill_ex, e); end
        n_run++; e = sb.pop_front(); if (a_kill_d !== e) begin n_fail++; $display("FAIL lu_kill_d got=%0h exp=%0h", a_kill_d, e); end
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL lu2_hold_pc_c1 got=%0h exp=%0h", b_hold_pc, e); end
        tick();
        // load moves to MEM behind a bubble; the ID consumer is still held
        ex_memread = 1'b0; ex_wen = 1'b0;
        mem_memread = 1'b1; mem_wen = 1'b1; mem_rd = 3'd2; mem_data = 32'hDEAD;
        wb_wen = 1'b1; wb_rd = 3'd2; wb_data = 32'hBEEF; ex_rs1 = 3'd2;
        sb.push_back(0); sb.push_back(1); sb.push_back(1); sb.push_back(32'hDEAD); sb.push_back(32'hBEEF);
        #1;
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL lu_hold_pc_c2 got=%0h exp=%0h", a_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL lu2_hold_pc_c2 got=%0h exp=%0h", b_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (b_kill_ex !== e) begin n_fail++; $display("FAIL lu2_kill_ex_c2 got=%0h exp=%0h", b_kill_ex, e); end
        n_run++; e = sb.pop_front(); if (a_fwd1 !== e) begin n_fail++; $display("FAIL lu_fwd_lat1 got=%0h exp=%0h", a_fwd1, e); end
        n_run++; e = sb.pop_front(); if (b_fwd1 !== e) begin n_fail++; $display("FAIL lu_fwd_lat2 got=%0h exp=%0h", b_fwd1, e); end
        tick();
        mem_memread = 1'b0; mem_wen = 1'b0;
        sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL lu2_hold_pc_c3 got=%0h exp=%0h", b_hold_pc, e); end
        tick();
        idle();
        sb.push_back(1); sb.push_back(2);
        #1;
        n_run++; e = sb.pop_front(); if (a_stl !== e) begin n_fail++; $display("FAIL lu_cnt_stalls got=%0h exp=%0h", a_stl, e); end
        n_run++; e = sb.pop_front(); if (b_stl !== e) begin n_fail++; $display("FAIL lu2_cnt_stalls got=%0h exp=%0h", b_stl, e); end
    endtask

    task automatic test_no_stall();
        do_reset();
        load_use_stim();
        id_rs1_used = 1'b0;
        sb.push_back(0); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL unused_hold_pc got=%0h exp=%0h", a_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL unused2_hold_pc got=%0h exp=%0h", b_hold_pc, e); end
        id_rs2 = 3'd2; id_rs2_used = 1'b1;
        sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL rs2_hold_pc got=%0h exp=%0h", a_hold_pc, e); end
        ex_rd = 3'd0; id_rs2 = 3'd0;
        sb.push_back(1); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL r0_hold_pc got=%0h exp=%0h", a_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL r0_zero_hold_pc got=%0h exp=%0h", b_hold_pc, e); end
        tick();
        idle();
        sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (b_stl !== e) begin n_fail++; $display("FAIL unused2_cnt_stalls got=%0h exp=%0h", b_stl, e); end
    endtask

    task automatic test_redirect();
        do_reset();
        load_use_stim();
        ex_redirect = 1'b1;
        sb.push_back(0); sb.push_back(0); sb.push_back(1); sb.push_back(1); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL rd_hold_pc got=%0h exp=%0h", b_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (b_hold_d !== e) begin n_fail++; $display("FAIL rd_hold_d got=%0h exp=%0h", b_hold_d, e); end
        n_run++; e = sb.pop_front(); if (b_kill_d !== e) begin n_fail++; $display("FAIL rd_kill_d got=%0h exp=%0h", b_kill_d, e); end
        n_run++; e = sb.pop_front(); if (b_kill_ex !== e) begin n_fail++; $display("FAIL rd_kill_ex got=%0h exp=%0h", b_kill_ex, e); end
        n_run++; e = sb.pop_front(); if (a_hold_pc !== e) begin n_fail++; $display("FAIL rd_hold_pc_lat1 got=%0h exp=%0h", a_hold_pc, e); end
        tick();
        idle();
        sb.push_back(0); sb.push_back(1); sb.push_back(1); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (b_hold_pc !== e) begin n_fail++; $display("FAIL rd_next_hold_pc got=%0h exp=%0h", b_hold_pc, e); end
        n_run++; e = sb.pop_front(); if (b_flu !== e) begin n_fail++; $display("FAIL rd_cnt_flushes got=%0h exp=%0h", b_flu, e); end
        n_run++; e = sb.pop_front(); if (a_flu !== e) begin n_fail++; $display("FAIL rd_cnt_flushes_lat1 got=%0h exp=%0h", a_flu, e); end
        n_run++; e = sb.pop_front(); if (b_stl !== e) begin n_fail++; $display("FAIL rd_cnt_stalls got=%0h exp=%0h", b_stl, e); end
    endtask

    task automatic test_halt_blocked();
        do_reset();
        load_use_stim();
        id_halt = 1'b1;
        tick();
        idle();
        sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL halt_stalled_fetch got=%0h exp=%0h", a_fetch, e); end
        id_halt = 1'b1; ex_redirect = 1'b1;
        tick();
        idle();
        sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL halt_wrongpath_fetch got=%0h exp=%0h", a_fetch, e); end
    endtask

    task automatic test_halt_drain();
        do_reset();
        id_halt = 1'b1;
        sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL halt_c0_fetch got=%0h exp=%0h", a_fetch, e); end
        tick();
        idle();
        sb.push_back(0); sb.push_back(1); sb.push_back(0); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL drain_fetch got=%0h exp=%0h", a_fetch, e); end
        n_run++; e = sb.pop_front(); if (a_kill_d !== e) begin n_fail++; $display("FAIL drain_kill_d got=%0h exp=%0h", a_kill_d, e); end
        n_run++; e = sb.pop_front(); if (a_halted !== e) begin n_fail++; $display("FAIL drain_halted got=%0h exp=%0h", a_halted, e); end
        n_run++; e = sb.pop_front(); if (a_kill_ex !== e) begin n_fail++; $display("FAIL drain_kill_ex got=%0h exp=%0h", a_kill_ex, e); end
        tick();
        tick();
        wb_halt = 1'b1;
        tick();
        wb_halt = 1'b0;
        sb.push_back(1); sb.push_back(1); sb.push_back(1); sb.push_back(0);
        #1;
        n_run++; e = sb.pop_front(); if (a_halted !== e) begin n_fail++; $display("FAIL halted_flag got=%0h exp=%0h", a_halted, e); end
        n_run++; e = sb.pop_front(); if (a_kill_ex !== e) begin n_fail++; $display("FAIL halted_kill_ex got=%0h exp=%0h", a_kill_ex, e); end
        n_run++; e = sb.pop_front(); if (a_kill_d !== e) begin n_fail++; $display("FAIL halted_kill_d got=%0h exp=%0h", a_kill_d, e); end
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL halted_fetch got=%0h exp=%0h", a_fetch, e); end
        repeat (3) tick();
        sb.push_back(4);
        #1;
        n_run++; e = sb.pop_front(); if (a_cyc !== e) begin n_fail++; $display("FAIL halted_cnt_frozen got=%0h exp=%0h", a_cyc, e); end
        rst = 1'b1;
        sb.push_back(0); sb.push_back(1); sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_halted !== e) begin n_fail++; $display("FAIL rsthalt_halted got=%0h exp=%0h", a_halted, e); end
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL rsthalt_fetch got=%0h exp=%0h", a_fetch, e); end
        n_run++; e = sb.pop_front(); if (a_kill_d !== e) begin n_fail++; $display("FAIL rsthalt_kill_d got=%0h exp=%0h", a_kill_d, e); end
        tick();
        rst = 1'b0;
        sb.push_back(0); sb.push_back(0); sb.push_back(1);
        #1;
        n_run++; e = sb.pop_front(); if (a_cyc !== e) begin n_fail++; $display("FAIL rsthalt_cnt_cycles got=%0h exp=%0h", a_cyc, e); end
        n_run++; e = sb.pop_front(); if (a_halted !== e) begin n_fail++; $display("FAIL after_rst_halted got=%0h exp=%0h", a_halted, e); end
        n_run++; e = sb.pop_front(); if (a_fetch !== e) begin n_fail++; $display("FAIL after_rst_fetch got=%0h exp=%0h", a_fetch, e); end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (20) tick();
        sb.push_back(15); sb.push_back(20);
        #1;
        n_run++; e = sb.pop_front(); if (c_cyc !== e) begin n_fail++; $display("FAIL sat_cnt_cycles got=%0h exp=%0h", c_cyc, e); end
        n_run++; e = sb.pop_front(); if (a_cyc !== e) begin n_fail++; $display("FAIL wide_cnt_cycles got=%0h exp=%0h", a_cyc, e); end
        tick();
        sb.push_back(15);
        #1;
        n_run++; e = sb.pop_front(); if (c_cyc !== e) begin n_fail++; $display("FAIL sat_hold got=%0h exp=%0h", c_cyc, e); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_halt_blocked();
        test_halt_drain();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
